duty_slew_ctrl: RTL and testbench
=================================

Name: duty_slew_ctrl

Overview:
- Upstream setpoint stage for the tt_um PWM generator. Produces the duty code and mode select that the PWM stage consumes.
- Filters and synchronises the raw pin inputs (target duty, mode request).
- Slews the applied duty toward the target by a bounded step once per N PWM periods.
- Forces duty to zero before any 960 Hz / 50 Hz mode change, so a servo never sees a full-scale PWM pulse.

Parameters:
- WIDTH, 7: duty code width.
- STEP, 1: duty increment or decrement applied per slew event.
- RATE_DIV, 4: number of period_tick_i pulses between slew events; legal range 1..255.
- STABLE_CYC, 16: consecutive identical synchronised samples required before a new target or mode request is accepted.
- SERVO_MAX, 15: maximum duty code while sel_o=1; larger targets are clamped.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous reset, active-low.
- ena, input, 1: block enable; when low, all state except the synchronisers is frozen.
- target_i, input, WIDTH: raw requested duty code, asynchronous to clk.
- sel_req_i, input, 1: raw mode request (0 = 960 Hz, 1 = 50 Hz servo), asynchronous.
- period_tick_i, input, 1: one-cycle pulse from the PWM stage at the start of each PWM period.
- duty_o, output, WIDTH: applied duty code sent to the PWM stage.
- sel_o, output, 1: applied mode sent to the PWM stage.
- busy_o, output, 1: high whenever state is not IDLE.
- done_o, output, 1: one-cycle pulse when duty_o reaches the accepted target.

Behaviour:
- Reset: rst_n sampled low at a clk edge clears everything on that edge. Resulting values: duty_o=0, sel_o=0, busy_o=0, done_o=0, state=IDLE, all counters 0, accepted target 0, accepted mode 0. Reset asserted mid-ramp aborts the ramp immediately.
- Input synchronisers: target_i and sel_req_i each pass through a 2-flop synchroniser.
- Stability filter:
  - The counter increments while the synchronised value equals the previous sample; it resets to 0 on any change.
  - At STABLE_CYC the value is accepted. Accepted-target latency is 2 + STABLE_CYC cycles after the input settles.
- Clamp: the effective target is min(accepted target, SERVO_MAX) when the accepted mode is 1; otherwise the accepted target unchanged.
- Rate counter: counts period_tick_i pulses. Reaching RATE_DIV produces a one-cycle slew event and restarts the count. The counter runs only in RAMP and DRAIN and is cleared on entry to either state.
- Slew arithmetic:
  - Each slew event moves duty_o toward its goal by STEP.
  - If |goal - duty_o| <= STEP, duty_o becomes the goal exactly. No overshoot, no wrap.
  - Compute in WIDTH+1 bits.
- FSM:
  - IDLE:
    - If accepted mode != sel_o, go to DRAIN.
    - Else if effective target != duty_o, go to RAMP.
  - RAMP (goal = effective target):
    - A target change mid-ramp retargets immediately; direction is re-evaluated at the next slew event.
    - If the accepted mode changes, go to DRAIN. The mode request has priority over the target.
    - When duty_o equals the goal: pulse done_o and go to IDLE.
  - DRAIN (goal = 0): when duty_o==0, go to SWITCH.
  - SWITCH (one cycle):
    - sel_o <= accepted mode, then go to RAMP.
    - If the request reverted during DRAIN, sel_o is unchanged and the FSM still goes to RAMP.
- Target equal to duty in RAMP: done_o pulses in the cycle after entry. A target equal to duty in IDLE produces no transition and no done_o.
- period_tick_i and a target acceptance in the same cycle: the slew event uses the pre-update goal; the new goal applies from the next cycle.
- ena=0:
  - All FSM, counters and outputs hold; done_o is forced to 0.
  - Synchronisers and the stability filter keep running.
  - period_tick_i pulses arriving while ena=0 are ignored.
- sel_o changes only in SWITCH, and only while duty_o==0.

Decomposition:
- Package duty_slew_pkg holds:
  - the FSM state encoding (IDLE, RAMP, DRAIN, SWITCH, 2 bits);
  - the mode constants MODE_960HZ=0 and MODE_SERVO=1;
  - the default SERVO_MAX.
- One sub-module, sync_stable, parameterised by width and STABLE_CYC. Instantiated twice: once for target_i, once for sel_req_i.

Test Plan:
1. Ramp up: after reset, target_i=10, mode 0, STEP=1, RATE_DIV=4, period_tick_i every 8 clk.
   Required: busy_o rises after 2+16 cycles; duty_o counts 1..10, one step per 32 clk; done_o pulses once; busy_o returns to 0.
2. Step clamp: STEP=3, duty_o=10, target_i=2.
   Required: duty_o goes 7, 4, 2, with no underflow.
3. Mode change: duty_o=20 in mode 0, sel_req_i=1, target_i=40.
   Required: duty_o drains to 0; sel_o goes high only after duty_o==0; duty_o then ramps to 15 (SERVO_MAX clamp).
4. Glitch rejection: target_i toggles every 5 cycles, or sel_req_i pulses for 10 cycles.
   Required: no acceptance; state stays IDLE; duty_o, sel_o unchanged.
5. Mid-ramp events: during a ramp 0→30, deassert ena for 100 cycles while period_tick_i keeps pulsing.
   Required: duty_o holds. After ena returns, drive rst_n low for one edge: duty_o=0, sel_o=0, busy_o=0 the next cycle.
6. Reverted request: during DRAIN, return sel_req_i to its original value.
   Required: drain completes to 0; sel_o unchanged; FSM goes to RAMP back to the original target; done_o pulses.

Source files
------------

// File: rtl/duty_slew_pkg.sv
// duty_slew_pkg: shared types and constants for the duty slew controller.
//   state_e        FSM state encoding (2 bits)
//   MODE_960HZ/MODE_SERVO  mode select values driven on sel_o
//   SERVO_MAX_DEF  default duty ceiling while in servo mode
package duty_slew_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        DRAIN  = 2'd2,
        SWITCH = 2'd3
    } state_e;

    localparam logic MODE_960HZ = 1'b0;
    localparam logic MODE_SERVO = 1'b1;

    localparam int SERVO_MAX_DEF = 15;

endpackage

// File: rtl/duty_slew_ctrl_sync_stable.sv
// sync_stable: 2-flop synchroniser followed by a stability filter.
//   clk, rst_n  clock, synchronous active-low reset
//   d_i         raw asynchronous input, W bits
//   q_o         accepted value; updates only after STABLE_CYC identical
//               synchronised samples (2 + STABLE_CYC cycles after d_i settles)
module sync_stable #(
    parameter int W          = 1,
    parameter int STABLE_CYC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    // STABLE_CYC identical samples means STABLE_CYC-1 back-to-back matches.
    localparam logic [CW-1:0] HIT = CW'(STABLE_CYC - 1);

    logic [W-1:0]  s1, s2, prev;
    logic [CW-1:0] cnt, cnt_n;

    always_comb begin
        cnt_n = cnt;
        if (s2 != prev)
            cnt_n = '0;
        else if (cnt != HIT)
            cnt_n = cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
            cnt  <= '0;
            q_o  <= '0;
        end else begin
            s1   <= d_i;
            s2   <= s1;
            prev <= s2;
            cnt  <= cnt_n;
            if (cnt_n == HIT)
                q_o <= s2;
        end
    end

endmodule

// File: rtl/duty_slew_ctrl.sv
// duty_slew_ctrl: setpoint stage ahead of the PWM generator.
//   clk, rst_n     clock, synchronous active-low reset
//   ena            block enable; low freezes FSM/counters/outputs
//   target_i       raw requested duty code (async)
//   sel_req_i      raw mode request, 0 = 960 Hz, 1 = 50 Hz servo (async)
//   period_tick_i  one-cycle pulse per PWM period
//   duty_o, sel_o  applied duty code and mode to the PWM stage
//   busy_o         high whenever the FSM is not IDLE
//   done_o         one-cycle pulse when duty_o reaches the accepted target
// Duty is slewed by STEP once every RATE_DIV PWM periods; any mode change
// first drains duty to zero so the new mode never starts on a large pulse.
module duty_slew_ctrl
    import duty_slew_pkg::*;
#(
    parameter int WIDTH      = 7,
    parameter int STEP       = 1,
    parameter int RATE_DIV   = 4,
    parameter int STABLE_CYC = 16,
    parameter int SERVO_MAX  = SERVO_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] target_i,
    input  logic             sel_req_i,
    input  logic             period_tick_i,
    output logic [WIDTH-1:0] duty_o,
    output logic             sel_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] SMAX      = WIDTH'(SERVO_MAX);
    localparam logic [7:0]       RATE_LAST = 8'(RATE_DIV - 1);

    logic [WIDTH-1:0] tgt_acc, eff_tgt, duty_q, duty_n;
    logic             mode_acc, sel_q, sel_n, done_q, done_n;
    logic [7:0]       rate_cnt, rate_n;
    logic             run, slew_evt, clr_rate;
    state_e           state, state_n;

    sync_stable #(.W(WIDTH), .STABLE_CYC(STABLE_CYC)) u_sync_tgt (
        .clk (clk), .rst_n (rst_n), .d_i (target_i), .q_o (tgt_acc)
    );

    sync_stable #(.W(1), .STABLE_CYC(STABLE_CYC)) u_sync_sel (
        .clk (clk), .rst_n (rst_n), .d_i (sel_req_i), .q_o (mode_acc)
    );

    // One bounded step toward goal; the extra bit keeps the distance
    // comparison free of wrap, and a short distance lands exactly on goal.
    function automatic logic [WIDTH-1:0] slew_to(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] goal);
        logic [WIDTH:0] c, g, r;
        c = {1'b0, cur};
        g = {1'b0, goal};
        r = g;
        if (g > c) begin
            if (g - c > STEP_W) r = c + STEP_W;
        end else if (c - g > STEP_W) begin
            r = c - STEP_W;
        end
        return r[WIDTH-1:0];
    endfunction

    // Clamp follows the accepted mode, so a pending servo request already
    // limits the goal the ramp after SWITCH heads for.
    assign eff_tgt  = (mode_acc == MODE_SERVO && tgt_acc > SMAX) ? SMAX : tgt_acc;
    assign run      = (state == RAMP) || (state == DRAIN);
    assign slew_evt = run && period_tick_i && (rate_cnt == RATE_LAST);

    always_comb begin
        state_n  = state;
        duty_n   = duty_q;
        sel_n    = sel_q;
        done_n   = 1'b0;
        clr_rate = 1'b0;
        case (state)
            IDLE: begin
                if (mode_acc != sel_q) begin
                    state_n  = DRAIN;
                    clr_rate = 1'b1;
                end else if (eff_tgt != duty_q) begin
                    state_n  = RAMP;
                    clr_rate = 1'b1;
                end
            end
            RAMP: begin
                // Mode request wins over any target movement.
                if (mode_acc != sel_q) begin
                    state_n  = DRAIN;
                    clr_rate = 1'b1;
                end else if (duty_q == eff_tgt) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (slew_evt) begin
                    duty_n = slew_to(duty_q, eff_tgt);
                end
            end
            DRAIN: begin
                if (duty_q == '0)
                    state_n = SWITCH;
                else if (slew_evt)
                    duty_n = slew_to(duty_q, '0);
            end
            SWITCH: begin
                // duty_q is zero here; a reverted request leaves sel unchanged.
                sel_n    = mode_acc;
                state_n  = RAMP;
                clr_rate = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rate_n = rate_cnt;
        if (clr_rate || !run)
            rate_n = '0;
        else if (period_tick_i)
            rate_n = slew_evt ? 8'd0 : rate_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty_q   <= '0;
            sel_q    <= MODE_960HZ;
            done_q   <= 1'b0;
            rate_cnt <= '0;
        end else if (ena) begin
            state    <= state_n;
            duty_q   <= duty_n;
            sel_q    <= sel_n;
            done_q   <= done_n;
            rate_cnt <= rate_n;
        end else begin
            done_q   <= 1'b0;
        end
    end

    assign duty_o = duty_q;
    assign sel_o  = sel_q;
    assign busy_o = (state != IDLE);
    assign done_o = done_q & ena;

endmodule

// File: tb/tb_duty_slew_ctrl.sv
module tb_duty_slew_ctrl;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic         sel_req = 1'b0;
    logic         tick = 1'b0;
    logic [W-1:0] target = '0;

    logic [W-1:0] duty1, duty3;
    logic         sel1, busy1, done1, sel3, busy3, done3;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc = 0, last_cyc = 0, tcnt = 0;
    int done_cnt = 0, done3_cnt = 0;
    bit tick_en = 1'b0;
    bit mon1_en = 1'b0, mon3_en = 1'b0, gap_en = 1'b0, have_prev = 1'b0;
    logic [W-1:0] last1 = '0, last3 = '0;
    logic         last_sel = 1'b0;

    // Scoreboard: expected duty/sel sequences, pushed when stimulus is driven.
    logic [W-1:0] exp1[$];
    logic [W-1:0] exp3[$];
    logic         exp_sel[$];

    duty_slew_ctrl #(.WIDTH(W), .STEP(1), .RATE_DIV(4), .STABLE_CYC(16), .SERVO_MAX(15)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .target_i(target), .sel_req_i(sel_req),
        .period_tick_i(tick), .duty_o(duty1), .sel_o(sel1), .busy_o(busy1), .done_o(done1)
    );

    duty_slew_ctrl #(.WIDTH(W), .STEP(3), .RATE_DIV(4), .STABLE_CYC(16), .SERVO_MAX(15)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .target_i(target), .sel_req_i(sel_req),
        .period_tick_i(tick), .duty_o(duty3), .sel_o(sel3), .busy_o(busy3), .done_o(done3)
    );

    always #5 clk = ~clk;

    // PWM period tick: one clk every 8.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            tick = tick_en && (tcnt % 8 == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Output monitor: pops the scoreboard on every duty/sel change.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (done1 === 1'b1) done_cnt++;
            if (done3 === 1'b1) done3_cnt++;
            if (duty1 !== last1) begin
                if (mon1_en) begin
                    if (exp1.size() == 0) chk("duty1_unexpected", 32'(duty1), 32'(last1));
                    else chk("duty1_seq", 32'(duty1), 32'(exp1.pop_front()));
                    if (gap_en) begin
                        if (have_prev) chk("step_gap", cyc - last_cyc, 32);
                        have_prev = 1'b1;
                        last_cyc  = cyc;
                    end
                end
                last1 = duty1;
            end
            if (sel1 !== last_sel) begin
                if (mon1_en) begin
                    chk("sel_at_zero_duty", 32'(duty1), 32'd0);
                    if (exp_sel.size() == 0) chk("sel_unexpected", 32'(sel1), 32'(last_sel));
                    else chk("sel_seq", 32'(sel1), 32'(exp_sel.pop_front()));
                end
                last_sel = sel1;
            end
            if (duty3 !== last3) begin
                if (mon3_en) begin
                    if (exp3.size() == 0) chk("duty3_unexpected", 32'(duty3), 32'(last3));
                    else chk("duty3_seq", 32'(duty3), 32'(exp3.pop_front()));
                end
                last3 = duty3;
            end
        end
    end

    task automatic push1(input int from, input int to);
        if (from <= to) for (int i = from; i <= to; i++) exp1.push_back(W'(i));
        else            for (int i = from; i >= to; i--) exp1.push_back(W'(i));
    endtask

    task automatic wait_idle(input string tag, input bit which, input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < max && ((which ? exp3.size() : exp1.size()) != 0 || (which ? busy3 : busy1)));
        chk(tag, 32'(n < max), 32'd1);
    endtask

    task automatic wait_duty(input string tag, input logic [W-1:0] val, input int max);
        int n;
        n = 0;
        while (duty1 !== val && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < max), 32'd1);
    endtask

    task automatic do_reset();
        mon1_en = 1'b0; mon3_en = 1'b0; gap_en = 1'b0;
        rst_n = 1'b0; ena = 1'b1; target = '0; sel_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        exp1.delete(); exp3.delete(); exp_sel.delete();
        done_cnt = 0; done3_cnt = 0;
    endtask

    initial begin
        int bc;
        tick_en = 1'b1;

        // Reset state
        rst_n = 1'b0; ena = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_duty", 32'(duty1), 32'd0);
        chk("rst_sel",  32'(sel1),  32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        do_reset();

        // 1. Ramp up 0 -> 10, one step per 32 clk
        mon1_en = 1'b1; gap_en = 1'b1; have_prev = 1'b0;
        push1(1, 10);
        @(posedge clk);
        #1 target = 7'd10;
        repeat (17) @(posedge clk);
        @(negedge clk);
        chk("t1_busy_early", 32'(busy1), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_busy_rise", 32'(busy1), 32'd1);
        wait_idle("t1_ramp_timeout", 1'b0, 1000);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_duty", 32'(duty1), 32'd10);
        gap_en = 1'b0;

        // 2. STEP=3: 0 -> 10 then down to 2 without underflow
        do_reset();
        mon3_en = 1'b1;
        exp3.push_back(7'd3); exp3.push_back(7'd6); exp3.push_back(7'd9); exp3.push_back(7'd10);
        target = 7'd10;
        wait_idle("t2_up_timeout", 1'b1, 1000);
        exp3.push_back(7'd7); exp3.push_back(7'd4); exp3.push_back(7'd2);
        target = 7'd2;
        wait_idle("t2_down_timeout", 1'b1, 1000);
        chk("t2_duty", 32'(duty3), 32'd2);
        chk("t2_done_cnt", 32'(done3_cnt), 32'd2);

        // 3. Mode change at duty 20: drain, switch, ramp to clamped 15
        do_reset();
        mon1_en = 1'b1;
        push1(1, 20);
        target = 7'd20;
        wait_idle("t3_ramp_timeout", 1'b0, 2000);
        chk("t3_sel_before", 32'(sel1), 32'd0);
        push1(19, 0);
        exp_sel.push_back(1'b1);
        push1(1, 15);
        sel_req = 1'b1; target = 7'd40;
        wait_idle("t3_mode_timeout", 1'b0, 4000);
        chk("t3_sel_after", 32'(sel1), 32'd1);
        chk("t3_duty_clamp", 32'(duty1), 32'd15);
        chk("t3_done_cnt", 32'(done_cnt), 32'd2);

        // 4. Glitch rejection: no acceptance, FSM stays IDLE
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            target = (i % 2 == 0) ? 7'd3 : 7'd40;
            repeat (5) begin @(negedge clk); if (busy1) bc++; end
        end
        sel_req = 1'b0;
        repeat (10) begin @(negedge clk); if (busy1) bc++; end
        sel_req = 1'b1;
        repeat (40) begin @(negedge clk); if (busy1) bc++; end
        chk("t4_busy_cycles", 32'(bc), 32'd0);
        chk("t4_duty", 32'(duty1), 32'd15);
        chk("t4_sel", 32'(sel1), 32'd1);

        // 5. ena low mid-ramp holds; then one-edge reset aborts the ramp
        do_reset();
        mon1_en = 1'b1;
        push1(1, 5);
        target = 7'd30;
        wait_duty("t5_reach5_timeout", 7'd5, 1000);
        ena = 1'b0;
        bc = done_cnt;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("t5_hold_duty", 32'(duty1), 32'd5);
        chk("t5_hold_busy", 32'(busy1), 32'd1);
        chk("t5_hold_nodone", 32'(done_cnt), 32'(bc));
        tick_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mon1_en = 1'b0; ena = 1'b1; target = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rst_duty", 32'(duty1), 32'd0);
        chk("t5_rst_sel",  32'(sel1),  32'd0);
        chk("t5_rst_busy", 32'(busy1), 32'd0);
        rst_n = 1'b1; tick_en = 1'b1;

        // 6. Mode request reverts during DRAIN
        do_reset();
        mon1_en = 1'b1;
        push1(1, 12);
        target = 7'd12;
        wait_idle("t6_ramp_timeout", 1'b0, 1000);
        chk("t6_done_first", 32'(done_cnt), 32'd1);
        push1(11, 0);
        push1(1, 12);
        sel_req = 1'b1;
        wait_duty("t6_drain_start_timeout", 7'd11, 1000);
        sel_req = 1'b0;
        wait_idle("t6_revert_timeout", 1'b0, 3000);
        chk("t6_sel", 32'(sel1), 32'd0);
        chk("t6_duty", 32'(duty1), 32'd12);
        chk("t6_done_cnt", 32'(done_cnt), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
